audio_codec_xcvr: RTL and testbench
===================================

Name: audio_codec_xcvr

Overview:
- Digital audio interface master for a WM8731/WM8731L codec.
- Generates MCLK, BCLK and the DAC/ADC LR clocks from the system clock.
- Serializes a stereo DAC sample word onto DACDAT and deserializes the ADCDAT stream into a stereo word.
- Sits between the audio datapath (req/valid word interface) and the codec pins. Codec register setup over I2C is handled elsewhere.

Parameters:
- WIDTH, 32, bits per stereo frame; left channel is [WIDTH-1:WIDTH/2], right is [WIDTH/2-1:0]. Must be even, ≥4.
- MCLK_DIV, 4, clk cycles per mclk period. Even, ≥2.
- BCLK_DIV, 16, clk cycles per bclk period. Even, ≥4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- dacdat_in  in  WIDTH  stereo sample to play, left in the MSB half
- dacdat_req  out  1  one-cycle pulse requesting the next dacdat_in
- adcdat_out  out  WIDTH  last captured stereo sample, left in the MSB half
- adcdat_vld  out  1  one-cycle pulse: adcdat_out updated
- mclk  out  1  codec master clock
- bclk  out  1  bit clock
- daclrc  out  1  DAC LR clock, high = left channel
- dacdat  out  1  serial DAC data
- adclrc  out  1  ADC LR clock, identical to daclrc
- adcdat  in  1  serial ADC data from codec

Behaviour:
- Reset (rst=0, async): all outputs 0; mclk/bclk counters 0; bit counter = WIDTH-1; shift registers 0.
- mclk: free-running divider, low for MCLK_DIV/2 clks then high for MCLK_DIV/2 clks.
- bclk: counter bc counts 0..BCLK_DIV-1 and wraps.
  - bclk=0 while bc<BCLK_DIV/2, else 1.
  - Falling event: bc wraps to 0. Rising event: bc==BCLK_DIV/2.
- Bit counter bit (0..WIDTH-1):
  - Increments (wrapping) on each falling event.
  - daclrc=adclrc=1 for bit<WIDTH/2, 0 otherwise.
  - Both LR clocks change on the same clk edge as bclk falls.
- Format: left-justified, MSB first.
  - MSB is driven on the falling edge where bit becomes 0.
  - Codec samples on the bclk rising edge.
- DAC path:
  - dacdat_req pulses for exactly one clk on the rising event of bit WIDTH-1.
  - On the next falling event (bit→0), dacdat_in is loaded into the TX shift register and its MSB appears on dacdat.
  - Each later falling event shifts left; dacdat = TX MSB.
  - dacdat_in is only sampled at load, so the user has BCLK_DIV/2 clks after the req pulse to present data.
  - The first req after reset occurs BCLK_DIV/2 clks after rst deasserts.
  - The first frame carries the word presented for that req.
- ADC path:
  - On each rising event, adcdat is shifted into the RX register LSB.
  - On the rising event of bit WIDTH-1, the completed word (including that last bit) is copied to adcdat_out.
  - adcdat_vld pulses high in the same cycle as that copy.
  - adcdat_out holds until the next frame's copy.
  - The first frame after reset is partial (captures only the last bit period); adcdat_vld still pulses and the word is don't-care.
- Simultaneous events: req and vld pulse on the same clk; there is no interaction between the paths.
- Reset mid-frame: immediate async return to reset values; framing restarts as after power-up.
- No backpressure: req is not acknowledged; the word present at load time is sent.

Decomposition:
- Package audio_codec_pkg holds:
  - default WIDTH
  - MCLK_DIV and BCLK_DIV defaults
  - LEFT_HI/LEFT_LO slice constants
- One sub-module, audio_codec_clkgen:
  - produces mclk and bclk
  - produces the falling/rising event strobes and the bit counter
  - produces daclrc/adclrc
- TX and RX shift registers stay in the top.

Test Plan:
- Reset: hold rst=0 for 100 ns, release → all outputs 0 during reset. First dacdat_req occurs 8 clks after release (defaults). bclk period = 16 clks; mclk period = 4 clks.
- DAC loopback: answer each req within 1 clk with a random word (e.g. 32'hA5C3_0F12) → a model sampling dacdat on bclk rising edges, MSB first from daclrc rising, reconstructs the identical word for ≥10 frames.
- ADC capture: model drives 32'h1234_ABCD MSB-first, changing on bclk falling edges → adcdat_vld pulses once per 512 clks and adcdat_out==32'h1234_ABCD (skip first frame), for ≥10 random frames.
- LR framing: daclrc==adclrc always; high exactly 16 bclk periods, low 16; edges coincide with bclk falling edges.
- Late data: change dacdat_in 3 clks after req (before load at 8) → new word transmitted. Change it 10 clks after req → previous word transmitted.
- Mid-frame reset: assert rst at bit 10 → outputs 0 immediately; after release, req timing and framing identical to the power-up case.

Source files
------------

// File: rtl/audio_codec_pkg.sv
// Shared defaults for the WM8731 digital audio interface master.
package audio_codec_pkg;
  localparam int WIDTH_DEF    = 32;
  localparam int MCLK_DIV_DEF = 4;
  localparam int BCLK_DIV_DEF = 16;
  localparam int LEFT_HI      = WIDTH_DEF - 1;
  localparam int LEFT_LO      = WIDTH_DEF / 2;
endpackage

// File: rtl/audio_codec_clkgen.sv
// Codec clock generation: mclk/bclk dividers, bit counter and LR clock.
module audio_codec_clkgen
  import audio_codec_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MCLK_DIV = MCLK_DIV_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb,
  output logic last_bit,
  output logic lrc
);
  localparam int MW = $clog2(MCLK_DIV);
  localparam int BW = $clog2(BCLK_DIV);
  localparam int NW = $clog2(WIDTH);
  localparam logic [MW-1:0] MC_LAST = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MC_HALF = MW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] BC_LAST = BW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BC_HALF = BW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BC_PRE_RISE = BW'(BCLK_DIV / 2 - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(WIDTH - 1);
  localparam logic [NW-1:0] BIT_HALF = NW'(WIDTH / 2);

  logic [MW-1:0] mc, mc_nxt;
  logic [BW-1:0] bc, bc_nxt;
  logic [NW-1:0] bit_idx, bit_nxt;

  assign mc_nxt  = (mc == MC_LAST) ? '0 : mc + MW'(1);
  assign bc_nxt  = (bc == BC_LAST) ? '0 : bc + BW'(1);
  assign bit_nxt = (bit_idx == BIT_LAST) ? '0 : bit_idx + NW'(1);

  // Strobes lead the bclk edge by one clk so registered actions land on that edge.
  assign fall_stb = (bc == BC_LAST);
  assign rise_stb = (bc == BC_PRE_RISE);
  assign last_bit = (bit_idx == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc      <= '0;
      bc      <= '0;
      bit_idx <= BIT_LAST;
      mclk    <= 1'b0;
      bclk    <= 1'b0;
      lrc     <= 1'b0;
    end else begin
      mc   <= mc_nxt;
      bc   <= bc_nxt;
      mclk <= (mc_nxt >= MC_HALF);
      bclk <= (bc_nxt >= BC_HALF);
      if (fall_stb) begin
        bit_idx <= bit_nxt;
        lrc     <= (bit_nxt < BIT_HALF);
      end
    end
  end
endmodule

// File: rtl/audio_codec_xcvr.sv
// Left-justified I2S-style master: serializes DAC words, deserializes ADC words.
module audio_codec_xcvr
  import audio_codec_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MCLK_DIV = MCLK_DIV_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dacdat_in,
  output logic             dacdat_req,
  output logic [WIDTH-1:0] adcdat_out,
  output logic             adcdat_vld,
  output logic             mclk,
  output logic             bclk,
  output logic             daclrc,
  output logic             dacdat,
  output logic             adclrc,
  input  logic             adcdat
);
  logic fall_stb, rise_stb, last_bit, lrc;
  logic [WIDTH-1:0] tx_sr, rx_sr;

  audio_codec_clkgen #(
    .WIDTH    (WIDTH),
    .MCLK_DIV (MCLK_DIV),
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .mclk     (mclk),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb),
    .last_bit (last_bit),
    .lrc      (lrc)
  );

  assign daclrc = lrc;
  assign adclrc = lrc;
  assign dacdat = tx_sr[WIDTH-1];

  // The last rising edge of a frame both requests the next DAC word and closes the ADC word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      adcdat_out <= '0;
      dacdat_req <= 1'b0;
      adcdat_vld <= 1'b0;
    end else begin
      dacdat_req <= rise_stb && last_bit;
      adcdat_vld <= rise_stb && last_bit;
      if (fall_stb) begin
        if (last_bit) tx_sr <= dacdat_in;
        else          tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      end
      if (rise_stb) begin
        rx_sr <= {rx_sr[WIDTH-2:0], adcdat};
        if (last_bit) adcdat_out <= {rx_sr[WIDTH-2:0], adcdat};
      end
    end
  end
endmodule

// File: tb/tb_audio_codec_xcvr.sv
// Self-checking bench: codec-side pin model reconstructs DAC words and drives ADC words.
module tb_audio_codec_xcvr;
  import audio_codec_pkg::*;

  localparam int W     = WIDTH_DEF;
  localparam int HB    = BCLK_DIV_DEF / 2;
  localparam int FRAME = W * BCLK_DIV_DEF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] dacdat_in = '0;
  logic         adcdat = 1'b0;
  logic         dacdat_req, adcdat_vld, mclk, bclk, daclrc, dacdat, adclrc;
  logic [W-1:0] adcdat_out;

  audio_codec_xcvr dut (
    .clk        (clk),
    .rst        (rst),
    .dacdat_in  (dacdat_in),
    .dacdat_req (dacdat_req),
    .adcdat_out (adcdat_out),
    .adcdat_vld (adcdat_vld),
    .mclk       (mclk),
    .bclk       (bclk),
    .daclrc     (daclrc),
    .dacdat     (dacdat),
    .adclrc     (adclrc),
    .adcdat     (adcdat)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Codec-side model state
  bit           auto_dac;
  logic         prev_bclk, prev_lrc;
  bit           bclk_rise, bclk_fall, lrc_rise, lrc_edge;
  int           pos, frames, cyc;
  logic [W-1:0] dac_mon, adc_cur;
  logic [W-1:0] dac_sent_q[$], dac_got_q[$], adc_sent_q[$], adc_got_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bclk_rise = bclk && !prev_bclk;
    bclk_fall = !bclk && prev_bclk;
    lrc_rise  = daclrc && !prev_lrc;
    lrc_edge  = daclrc != prev_lrc;
    if (bclk_fall) begin
      if (lrc_rise) begin
        pos = 0;
        frames++;
        adc_cur = (frames == 1) ? 32'h1234_ABCD : $urandom();
        adc_sent_q.push_back(adc_cur);
      end else if (pos >= 0) begin
        pos++;
      end
      if (pos >= 0 && pos < W) adcdat = adc_cur[W-1-pos];
    end
    if (bclk_rise && pos >= 0 && pos < W) begin
      dac_mon = {dac_mon[W-2:0], dacdat};
      if (pos == W - 1) dac_got_q.push_back(dac_mon);
    end
    if (adcdat_vld && frames > 0) adc_got_q.push_back(adcdat_out);
    if (dacdat_req && auto_dac) begin
      dacdat_in = (dac_sent_q.size() == 0) ? 32'hA5C3_0F12 : $urandom();
      dac_sent_q.push_back(dacdat_in);
    end
    prev_bclk = bclk;
    prev_lrc  = daclrc;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    prev_bclk = 1'b0;
    prev_lrc  = 1'b0;
    pos = -1;
    frames = 0;
    cyc = 0;
    dac_mon = '0;
    adcdat = 1'b1;
    dacdat_in = '0;
    dac_sent_q.delete();
    dac_got_q.delete();
    adc_sent_q.delete();
    adc_got_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    auto_dac = 1'b0;
    rst = 1'b0;
    #100;
    tests_run++;
    if ({mclk, bclk, daclrc, adclrc, dacdat, dacdat_req, adcdat_vld} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0", {mclk, bclk, daclrc, adclrc, dacdat, dacdat_req, adcdat_vld});
    end
    tests_run++;
    if (adcdat_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_adcdat_out: got %h expected 0", adcdat_out);
    end
    release_reset();
    n = 0;
    while (!dacdat_req && n < 40) begin step(); n++; end
    tests_run++;
    if (n != HB) begin
      tests_failed++;
      $display("FAIL first_req_latency: got %0d expected %0d", n, HB);
    end
    while (!lrc_rise && n < 60) begin step(); n++; end
    tests_run++;
    if (cyc != 2 * HB) begin
      tests_failed++;
      $display("FAIL first_lrc_rise: got %0d expected %0d", cyc, 2 * HB);
    end
  endtask

  task automatic test_clocks();
    int last_mr, last_br, last_bf;
    logic pm, pb;
    release_reset();
    last_mr = -1; last_br = -1; last_bf = -1;
    pm = 1'b0; pb = 1'b0;
    for (int i = 0; i < 4 * BCLK_DIV_DEF; i++) begin
      step();
      if (mclk && !pm) begin
        if (last_mr >= 0) begin
          tests_run++;
          if (cyc - last_mr != MCLK_DIV_DEF) begin
            tests_failed++;
            $display("FAIL mclk_period: got %0d expected %0d", cyc - last_mr, MCLK_DIV_DEF);
          end
        end
        last_mr = cyc;
      end
      if (bclk && !pb) begin
        if (last_br >= 0) begin
          tests_run++;
          if (cyc - last_br != BCLK_DIV_DEF) begin
            tests_failed++;
            $display("FAIL bclk_period: got %0d expected %0d", cyc - last_br, BCLK_DIV_DEF);
          end
        end
        last_br = cyc;
      end
      if (!bclk && pb && last_br >= 0) begin
        tests_run++;
        if (cyc - last_br != HB) begin
          tests_failed++;
          $display("FAIL bclk_high: got %0d expected %0d", cyc - last_br, HB);
        end
      end
      pm = mclk;
      pb = bclk;
    end
  endtask

  task automatic test_dac_loopback();
    int n;
    release_reset();
    auto_dac = 1'b1;
    n = 0;
    while (dac_got_q.size() < 10 && n < 11 * FRAME + 100) begin step(); n++; end
    auto_dac = 1'b0;
    tests_run++;
    if (dac_got_q.size() < 10 || dac_sent_q.size() < 10) begin
      tests_failed++;
      $display("FAIL dac_loopback_timeout: got %0d frames expected 10", dac_got_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (dac_got_q[i] !== dac_sent_q[i]) begin
          tests_failed++;
          $display("FAIL dac_frame%0d: got %h expected %h (left %h)", i, dac_got_q[i], dac_sent_q[i],
                   dac_sent_q[i][LEFT_HI:LEFT_LO]);
        end
      end
    end
  endtask

  task automatic test_adc_capture();
    int n, last_v, hold_err;
    logic [W-1:0] held;
    release_reset();
    n = 0; last_v = -1; hold_err = 0; held = '0;
    while (adc_got_q.size() < 10 && n < 11 * FRAME + 100) begin
      step();
      n++;
      if (adcdat_vld) begin
        if (last_v >= 0) begin
          tests_run++;
          if (cyc - last_v != FRAME) begin
            tests_failed++;
            $display("FAIL adc_vld_interval: got %0d expected %0d", cyc - last_v, FRAME);
          end
        end
        last_v = cyc;
        held = adcdat_out;
      end else if (last_v >= 0 && adcdat_out !== held) begin
        hold_err++;
      end
    end
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++;
      $display("FAIL adc_hold: got %0d changes expected 0", hold_err);
    end
    tests_run++;
    if (adc_got_q.size() < 10) begin
      tests_failed++;
      $display("FAIL adc_capture_timeout: got %0d words expected 10", adc_got_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (adc_got_q[i] !== adc_sent_q[i]) begin
          tests_failed++;
          $display("FAIL adc_frame%0d: got %h expected %h", i, adc_got_q[i], adc_sent_q[i]);
        end
      end
    end
  endtask

  task automatic test_lr_framing();
    int lr_diff, off_edge, last_e, n_edges;
    release_reset();
    lr_diff = 0; off_edge = 0; last_e = -1; n_edges = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (adclrc !== daclrc) lr_diff++;
      if (lrc_edge) begin
        if (!bclk_fall) off_edge++;
        if (last_e >= 0) begin
          tests_run++;
          if (cyc - last_e != FRAME / 2) begin
            tests_failed++;
            $display("FAIL lrc_half_period: got %0d expected %0d", cyc - last_e, FRAME / 2);
          end
        end
        last_e = cyc;
        n_edges++;
      end
    end
    tests_run++;
    if (lr_diff != 0) begin
      tests_failed++;
      $display("FAIL adclrc_eq_daclrc: got %0d differing cycles expected 0", lr_diff);
    end
    tests_run++;
    if (off_edge != 0 || n_edges < 5) begin
      tests_failed++;
      $display("FAIL lrc_on_bclk_fall: got %0d off-edge of %0d edges expected 0 of >=5", off_edge, n_edges);
    end
  endtask

  task automatic test_late_data();
    int n;
    logic [W-1:0] wb, wc;
    release_reset();
    auto_dac = 1'b0;
    wb = $urandom();
    wc = $urandom();
    n = 0;
    while (!dacdat_req && n < FRAME) begin step(); n++; end
    dacdat_in = $urandom();
    repeat (3) step();
    dacdat_in = wb;
    n = 0;
    step();
    while (!dacdat_req && n < FRAME + 10) begin step(); n++; end
    dacdat_in = wc;
    repeat (10) step();
    dacdat_in = ~wc;
    n = 0;
    while (dac_got_q.size() < 2 && n < 2 * FRAME) begin step(); n++; end
    tests_run++;
    if (dac_got_q.size() < 2) begin
      tests_failed++;
      $display("FAIL late_data_timeout: got %0d frames expected 2", dac_got_q.size());
    end else begin
      tests_run++;
      if (dac_got_q[0] !== wb) begin
        tests_failed++;
        $display("FAIL late_data_3clk: got %h expected %h", dac_got_q[0], wb);
      end
      tests_run++;
      if (dac_got_q[1] !== wc) begin
        tests_failed++;
        $display("FAIL late_data_10clk: got %h expected %h", dac_got_q[1], wc);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    release_reset();
    auto_dac = 1'b1;
    n = 0;
    while (!(pos == 10 && bclk_fall) && n < 2 * FRAME) begin step(); n++; end
    repeat (HB + 2) step();
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({mclk, bclk, daclrc, adclrc, dacdat, dacdat_req, adcdat_vld} !== 7'b0 || adcdat_out !== '0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got %b/%h expected 0/0",
               {mclk, bclk, daclrc, adclrc, dacdat, dacdat_req, adcdat_vld}, adcdat_out);
    end
    release_reset();
    n = 0;
    while (!dacdat_req && n < 40) begin step(); n++; end
    tests_run++;
    if (n != HB) begin
      tests_failed++;
      $display("FAIL midframe_req_latency: got %0d expected %0d", n, HB);
    end
    while (!lrc_rise && n < 60) begin step(); n++; end
    tests_run++;
    if (cyc != 2 * HB) begin
      tests_failed++;
      $display("FAIL midframe_lrc_rise: got %0d expected %0d", cyc, 2 * HB);
    end
    while (dac_got_q.size() < 3 && n < 4 * FRAME) begin step(); n++; end
    auto_dac = 1'b0;
    tests_run++;
    if (dac_got_q.size() < 3) begin
      tests_failed++;
      $display("FAIL midframe_loopback_timeout: got %0d frames expected 3", dac_got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (dac_got_q[i] !== dac_sent_q[i]) begin
          tests_failed++;
          $display("FAIL midframe_frame%0d: got %h expected %h", i, dac_got_q[i], dac_sent_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_dac_loopback();
    test_adc_capture();
    test_lr_framing();
    test_late_data();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
